// File: rtl/ste_cycle_ctrl.sv
// STEbus slave cycle sequencer: decodes the MIO address window and walks chip
// select, rd/wr strobes and datack through SETUP, STROBE, ACK and RELEASE.
module ste_cycle_ctrl #(
    parameter int WS_KBD  = 1,
    parameter int WS_SND  = 1,
    parameter int WS_PRN  = 4,
    parameter int WS_CF   = 6,
    parameter int WS_RTC  = 8,
    parameter int TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] addr,
    input  logic       cm0,
    input  logic       ce,
    input  logic       dev_ready,
    output logic       datack,
    output logic       cs_keyboard,
    output logic       cs_sound,
    output logic       cs_printer,
    output logic       cs_compactflash,
    output logic       cs_rtc,
    output logic       rd,
    output logic       wr,
    output logic       bus_err
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_ACK     = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam int R_KBD = 0;
    localparam int R_SND = 1;
    localparam int R_PRN = 2;
    localparam int R_CF  = 3;
    localparam int R_RTC = 4;

    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT - 1);

    logic [2:0] state_reg;
    logic       ce_meta_reg;
    logic       ce_s_reg;
    logic [4:1] addr_reg;
    logic       cm0_reg;
    logic [3:0] wait_cnt_reg;
    logic [5:0] tmo_cnt_reg;
    logic       bus_err_reg;

    logic [4:0] region;
    logic [3:0] ws_sel;
    logic       cs_active;
    logic       strobe_on;

    // Byte-wide peripherals ignore A0; it never affects the decode.
    logic unused_addr0;
    assign unused_addr0 = addr[0];

    // Priority decode of the latched address guarantees exactly one region.
    always_comb begin
        region = '0;
        if (addr_reg[4])      region[R_RTC] = 1'b1;
        else if (addr_reg[3]) region[R_CF]  = 1'b1;
        else if (addr_reg[2]) region[R_PRN] = 1'b1;
        else if (addr_reg[1]) region[R_SND] = 1'b1;
        else                  region[R_KBD] = 1'b1;
    end

    always_comb begin
        ws_sel = 4'(WS_KBD);
        if (region[R_SND]) ws_sel = 4'(WS_SND);
        if (region[R_PRN]) ws_sel = 4'(WS_PRN);
        if (region[R_CF])  ws_sel = 4'(WS_CF);
        if (region[R_RTC]) ws_sel = 4'(WS_RTC);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            ce_meta_reg  <= 1'b1;
            ce_s_reg     <= 1'b1;
            addr_reg     <= '0;
            cm0_reg      <= 1'b0;
            wait_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
            bus_err_reg  <= 1'b0;
        end else begin
            ce_meta_reg <= ce;
            ce_s_reg    <= ce_meta_reg;
            bus_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!ce_s_reg) begin
                        state_reg <= ST_SETUP;
                        addr_reg  <= addr[4:1];
                        cm0_reg   <= cm0;
                    end
                end
                ST_SETUP: begin
                    wait_cnt_reg <= ws_sel;
                    tmo_cnt_reg  <= '0;
                    state_reg    <= ce_s_reg ? ST_RELEASE : ST_STROBE;
                end
                ST_STROBE: begin
                    if (wait_cnt_reg != 4'd0) wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    tmo_cnt_reg <= tmo_cnt_reg + 6'd1;
                    // Master abort wins over a completion in the same cycle.
                    if (ce_s_reg) begin
                        state_reg <= ST_RELEASE;
                    end else if (wait_cnt_reg == 4'd0 && (!region[R_CF] || dev_ready)) begin
                        state_reg <= ST_ACK;
                    end else if (tmo_cnt_reg == TIMEOUT_LAST) begin
                        state_reg   <= ST_ACK;
                        bus_err_reg <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (ce_s_reg) state_reg <= ST_RELEASE;
                end
                ST_RELEASE: state_reg <= ST_IDLE;
                default:    state_reg <= ST_IDLE;
            endcase
        end
    end

    // Chip select spans SETUP through RELEASE to give address hold time.
    assign cs_active = (state_reg != ST_IDLE);
    assign strobe_on = (state_reg == ST_STROBE) || (state_reg == ST_ACK);

    assign datack          = (state_reg != ST_ACK);
    assign rd              = !(strobe_on && cm0_reg);
    assign wr              = !(strobe_on && !cm0_reg);
    assign cs_keyboard     = cs_active && region[R_KBD];
    assign cs_sound        = cs_active && region[R_SND];
    assign cs_printer      = !(cs_active && region[R_PRN]);
    assign cs_compactflash = !(cs_active && region[R_CF]);
    assign cs_rtc          = !(cs_active && region[R_RTC]);
    assign bus_err         = bus_err_reg;

endmodule

// File: tb/tb_ste_cycle_ctrl.sv
// Self-checking bench for ste_cycle_ctrl: a phase-level reference model is
// compared every cycle, plus directed cycles with hand-computed timings.
module tb_ste_cycle_ctrl;

    localparam int TIMEOUT = 40;
    localparam int P_IDLE = 0, P_SETUP = 1, P_STROBE = 2, P_ACK = 3, P_RELEASE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] addr = '0;
    logic       cm0 = 1'b0;
    logic       ce = 1'b1;
    logic       dev_ready = 1'b1;
    logic       datack, cs_keyboard, cs_sound, cs_printer, cs_compactflash, cs_rtc;
    logic       rd, wr, bus_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic cmp_en = 1'b0;

    ste_cycle_ctrl #(
        .WS_KBD(1), .WS_SND(1), .WS_PRN(4), .WS_CF(6), .WS_RTC(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .cm0(cm0), .ce(ce), .dev_ready(dev_ready),
        .datack(datack), .cs_keyboard(cs_keyboard), .cs_sound(cs_sound),
        .cs_printer(cs_printer), .cs_compactflash(cs_compactflash), .cs_rtc(cs_rtc),
        .rd(rd), .wr(wr), .bus_err(bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Region index by address range: 0 kbd, 1 sound, 2 printer, 3 CF, 4 RTC.
    function automatic int region_of(input logic [4:0] a);
        int v;
        v = int'(a);
        if (v >= 16) return 4;
        if (v >= 8)  return 3;
        if (v >= 4)  return 2;
        if (v >= 2)  return 1;
        return 0;
    endfunction

    function automatic int ws_of(input int r);
        case (r)
            0: return 1;
            1: return 1;
            2: return 4;
            3: return 6;
            default: return 8;
        endcase
    endfunction

    // Reference model: phase plus the number of completed STROBE edges.
    int         m_phase = P_IDLE;
    int         m_nstrobe = 0;
    logic [4:0] m_addr = '0;
    logic       m_cm0 = 1'b0;
    logic       m_berr = 1'b0;
    logic [1:0] m_sync = 2'b11;
    logic       m_ce_s;
    logic       m_ready_ok;

    always @(posedge clk) begin
        m_ce_s = m_sync[1];
        if (!reset) begin
            m_phase = P_IDLE;
            m_berr  = 1'b0;
            m_sync  = 2'b11;
        end else begin
            m_berr = 1'b0;
            case (m_phase)
                P_IDLE: if (!m_ce_s) begin
                    m_phase = P_SETUP;
                    m_addr  = addr;
                    m_cm0   = cm0;
                end
                P_SETUP: begin
                    m_nstrobe = 0;
                    m_phase   = m_ce_s ? P_RELEASE : P_STROBE;
                end
                P_STROBE: begin
                    m_ready_ok = (region_of(m_addr) != 3) || dev_ready;
                    if (m_ce_s) m_phase = P_RELEASE;
                    else if (m_nstrobe >= ws_of(region_of(m_addr)) && m_ready_ok) m_phase = P_ACK;
                    else if (m_nstrobe == TIMEOUT - 1) begin
                        m_phase = P_ACK;
                        m_berr  = 1'b1;
                    end else m_nstrobe++;
                end
                P_ACK: if (m_ce_s) m_phase = P_RELEASE;
                default: m_phase = P_IDLE;
            endcase
            m_sync = {m_sync[0], ce};
        end
    end

    int   e_region;
    logic e_busy, e_drive, e_datack, e_rd, e_wr, e_kbd, e_snd, e_prn, e_cf, e_rtc, e_berr;

    always_comb begin
        e_region = region_of(m_addr);
        e_busy   = (m_phase != P_IDLE);
        e_drive  = (m_phase == P_STROBE) || (m_phase == P_ACK);
        e_datack = (m_phase != P_ACK);
        e_rd     = !(e_drive && m_cm0);
        e_wr     = !(e_drive && !m_cm0);
        e_kbd    = e_busy && (e_region == 0);
        e_snd    = e_busy && (e_region == 1);
        e_prn    = !(e_busy && (e_region == 2));
        e_cf     = !(e_busy && (e_region == 3));
        e_rtc    = !(e_busy && (e_region == 4));
        e_berr   = m_berr;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_datack", int'(datack), int'(e_datack));
            chk("cmp_rd", int'(rd), int'(e_rd));
            chk("cmp_wr", int'(wr), int'(e_wr));
            chk("cmp_cs_keyboard", int'(cs_keyboard), int'(e_kbd));
            chk("cmp_cs_sound", int'(cs_sound), int'(e_snd));
            chk("cmp_cs_printer", int'(cs_printer), int'(e_prn));
            chk("cmp_cs_compactflash", int'(cs_compactflash), int'(e_cf));
            chk("cmp_cs_rtc", int'(cs_rtc), int'(e_rtc));
            chk("cmp_bus_err", int'(bus_err), int'(e_berr));
        end
    end

    // One STEbus cycle starting at a negedge; k counts edges from E0.
    // ready_at: -1 ready always high, -2 stuck low, n>=0 rises after edge n.
    task automatic run_txn(input logic [4:0] a, input logic c, input int ready_at,
                           input int abort_at, input int hold,
                           output int ack_k, output int model_ack_k, output int strobe_cycles,
                           output int berr_cycles, output int sel_k2);
        int e0, k, raised_k;
        bit done;
        addr = a;
        cm0 = c;
        dev_ready = (ready_at == -1);
        ce = 1'b0;
        e0 = cyc + 1;
        ack_k = -1; model_ack_k = -1; strobe_cycles = 0; berr_cycles = 0; sel_k2 = 0;
        raised_k = -1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            k = cyc - e0;
            if ((rd == 1'b0 || wr == 1'b0) && datack == 1'b1) strobe_cycles++;
            if (bus_err) berr_cycles++;
            if (datack == 1'b0 && ack_k < 0) ack_k = k;
            if (e_datack == 1'b0 && model_ack_k < 0) model_ack_k = k;
            if (k == 2) sel_k2 = {cs_keyboard, cs_sound, !cs_printer, !cs_compactflash, !cs_rtc};
            if (k == ready_at) dev_ready = 1'b1;
            if (raised_k < 0 && (k == abort_at || (ack_k >= 0 && k >= ack_k + hold))) begin
                ce = 1'b1;
                raised_k = k;
            end
            if (raised_k >= 0 && k >= raised_k + 5) done = 1'b1;
        end
        chk("txn_completed_in_budget", int'(done), 1);
        $display("txn addr=%b cm0=%0d ack_k=%0d strobe=%0d bus_err=%0d", a, c, ack_k,
                 strobe_cycles, berr_cycles);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int ack_k, mack_k, strb, berr, sel;
    int run_left, rmode;

    initial begin
        reset = 1'b0;
        ce = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_datack", int'(datack), 1);
        chk("reset_rd", int'(rd), 1);
        chk("reset_wr", int'(wr), 1);
        chk("reset_cs_keyboard", int'(cs_keyboard), 0);
        chk("reset_cs_rtc", int'(cs_rtc), 1);
        chk("reset_bus_err", int'(bus_err), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Keyboard read: SETUP at E2, rd low E3..E4, datack low from E5.
        run_txn(5'b00001, 1'b1, -1, -1, 3, ack_k, mack_k, strb, berr, sel);
        chk("kbd_ack_edge", ack_k, 5);
        chk("kbd_model_ack_edge", mack_k, 5);
        chk("kbd_strobe_width", strb, 2);
        chk("kbd_cs_at_setup", sel, 5'b10000);

        // RTC write: 9 cycles of wr, datack at E12, no bus error.
        run_txn(5'b10011, 1'b0, -1, -1, 2, ack_k, mack_k, strb, berr, sel);
        chk("rtc_ack_edge", ack_k, 12);
        chk("rtc_model_ack_edge", mack_k, 12);
        chk("rtc_strobe_width", strb, 9);
        chk("rtc_bus_err", berr, 0);
        chk("rtc_cs_at_setup", sel, 5'b00001);

        // CF read stalled 20 cycles past its wait states.
        run_txn(5'b01000, 1'b1, 29, -1, 2, ack_k, mack_k, strb, berr, sel);
        chk("cf_stall_ack_edge", ack_k, 30);
        chk("cf_stall_model_ack_edge", mack_k, 30);
        chk("cf_stall_bus_err", berr, 0);

        // CF read with ready stuck low: timeout after 40 STROBE cycles.
        run_txn(5'b01101, 1'b1, -2, -1, 4, ack_k, mack_k, strb, berr, sel);
        chk("cf_timeout_ack_edge", ack_k, 43);
        chk("cf_timeout_model_ack_edge", mack_k, 43);
        chk("cf_timeout_strobe_cycles", strb, 40);
        chk("cf_timeout_bus_err_cycles", berr, 1);

        // Printer write aborted so that abort and completion coincide at E8.
        run_txn(5'b00110, 1'b0, -1, 5, 0, ack_k, mack_k, strb, berr, sel);
        chk("abort_no_datack", ack_k, -1);
        chk("abort_model_no_datack", mack_k, -1);
        chk("abort_strobe_cycles", strb, 5);

        // Reset asserted during ACK drops the cycle immediately.
        addr = 5'b00000; cm0 = 1'b1; dev_ready = 1'b1; ce = 1'b0;
        ack_k = -1;
        for (int i = 0; i < 30 && ack_k < 0; i++) begin
            @(negedge clk);
            if (datack == 1'b0) ack_k = i;
        end
        chk("rst_reached_ack", int'(ack_k >= 0), 1);
        reset = 1'b0;
        ce = 1'b1;
        @(negedge clk);
        chk("rst_mid_datack", int'(datack), 1);
        chk("rst_mid_rd", int'(rd), 1);
        chk("rst_mid_cs_keyboard", int'(cs_keyboard), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        run_txn(5'b00011, 1'b0, -1, -1, 1, ack_k, mack_k, strb, berr, sel);
        chk("after_rst_ack_edge", ack_k, 5);
        chk("after_rst_cs_at_setup", sel, 5'b01000);

        // Randomized traffic including aborts, stalls, timeouts and resets.
        run_left = 0;
        rmode = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                ce = ~ce;
                if (ce) run_left = $urandom_range(1, 6);
                else if ($urandom_range(0, 3) == 0) run_left = $urandom_range(1, 8);
                else run_left = $urandom_range(10, 60);
            end
            run_left--;
            if (i % 200 == 0) rmode = $urandom_range(0, 2);
            addr = 5'($urandom);
            cm0 = 1'($urandom);
            dev_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
            reset = ($urandom_range(0, 599) != 0);
            @(negedge clk);
        end
        reset = 1'b1;
        ce = 1'b1;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ste_cycle_ctrl.md
# ste_cycle_ctrl

STEbus slave cycle sequencer for the MIO board. Sits between the STEbus control lines (`ce`, `cm0`, `addr`) and the on-board peripherals (keyboard, sound, printer, CompactFlash, RTC). It decodes the address window, sequences chip select, read/write strobes and `datack` through setup, wait-state, acknowledge and release phases. Wait-state counts are programmable per region, and a CompactFlash ready stall is bounded by a timeout.

## Interface
- `WS_KBD`, default 1: wait states for the keyboard region (0..15).
- `WS_SND`, default 1: wait states for the sound region.
- `WS_PRN`, default 4: wait states for the printer region.
- `WS_CF`, default 6: wait states for the CompactFlash region.
- `WS_RTC`, default 8: wait states for the RTC region.
- `TIMEOUT`, default 40: maximum cycles spent in STROBE (1..63). Must be greater than every `WS_*`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-low reset.
- `addr`  in  5  STEbus address.
- `cm0`  in  1  command: 0 = write, 1 = read.
- `ce`  in  1  STEbus chip enable, active low, asynchronous to `clk`.
- `dev_ready`  in  1  CompactFlash ready, active high; ignored for other regions.
- `datack`  out  1  STEbus data acknowledge, active low.
- `cs_keyboard`  out  1  active high; asserted when `addr[4:1]`=0000.
- `cs_sound`  out  1  active high; asserted when `addr[4:1]`=0001.
- `cs_printer`  out  1  active low; selected when `addr[4:2]`=001.
- `cs_compactflash`  out  1  active low; selected when `addr[4:3]`=01.
- `cs_rtc`  out  1  active low; selected when `addr[4]`=1.
- `rd`  out  1  read strobe, active low.
- `wr`  out  1  write strobe, active low.
- `bus_err`  out  1  one-cycle pulse, active high, when a cycle is closed by timeout.

## Operation
- `ce` passes through a 2-flop synchronizer. `ce_s` denotes the synchronizer output.
- `addr` and `cm0` are captured into registers on the IDLE->SETUP transition. All outputs are driven from registered state only.
- Exactly one region is selected per cycle. Wait count: `ws` = the `WS_*` value for the decoded region (4-bit).
- Reset (`reset`=0 at an edge): the state goes to IDLE and all outputs become inactive on that edge:
  - `datack`=1, `rd`=1, `wr`=1;
  - `cs_printer`=1, `cs_compactflash`=1, `cs_rtc`=1;
  - `cs_keyboard`=0, `cs_sound`=0;
  - `bus_err`=0, counters cleared.
  - This applies mid-cycle as well: the cycle is dropped with no `datack`.
- State machine:
  - IDLE: all outputs inactive. `ce_s`=0 -> SETUP (latch `addr`/`cm0`).
  - SETUP (1 cycle): region chip select asserted, strobes inactive. Load wait counter with `ws`, clear timeout counter -> STROBE. If `ce_s`=1 -> RELEASE (abort).
  - STROBE: chip select asserted. `rd`=0 if `cm0`=1, else `wr`=0.
    - Each cycle: wait counter decrements while nonzero; timeout counter increments.
    - Wait counter = 0 and (region != CF or `dev_ready`=1) -> ACK.
    - Otherwise timeout counter = `TIMEOUT`-1 -> ACK, with a `bus_err` pulse on entry to ACK.
    - `ce_s`=1 (master abort) -> RELEASE with no `datack`. Abort has priority over completion in the same cycle.
  - ACK: `datack`=0; strobe and chip select held, so read data stays driven. `ce_s`=1 -> RELEASE.
  - RELEASE (1 cycle): `datack`=1, strobes inactive, chip select still asserted (hold time) -> IDLE.
- A new falling edge of `ce` seen during RELEASE is not lost: IDLE samples `ce_s` and starts the next cycle on the following edge.

## Timing
- Reference edge E0 is the first `clk` edge that samples `ce`=0. `ce_s`=0 after E1, so SETUP is entered at E2 and STROBE at E3.
- Strobe low width is `ws`+1 cycles when not stalled. ACK is entered at E4+`ws`, and `datack` is low from then on.
- Stalled CF cycle: ACK follows one edge after `dev_ready` is sampled high with the wait counter at 0.
- Timeout: at most `TIMEOUT` cycles in STROBE. `bus_err` is high for exactly the first ACK cycle.
- Release: `ce` is sampled high at edge R0; RELEASE is entered at R2 and IDLE at R3. `datack` returns high at R2.
- Minimum idle between cycles: 1 cycle (IDLE).

## Test plan
- Keyboard read, `addr`=00001, `cm0`=1, `WS_KBD`=1 -> `cs_keyboard`=1 from E2, `rd`=0 for cycles E3..E4, `datack`=0 from E5, all outputs inactive by R3.
- RTC write, `addr`=10011, `cm0`=0 -> `cs_rtc`=0, `wr` low for 9 cycles, `rd` stays 1, `datack`=0 at E12, `bus_err` never set.
- CF read with `dev_ready` held low for 20 cycles beyond `WS_CF` -> `rd` remains low until `dev_ready` rises, then `datack`=0 on the next edge, `bus_err`=0.
- CF read with `dev_ready` stuck low -> ACK after exactly 40 STROBE cycles, `bus_err`=1 for one cycle, `datack`=0 until `ce` rises.
- Master abort: `ce` rises during STROBE of a printer write -> `datack` never asserts, `wr` returns high at RELEASE, IDLE one cycle later.
- `reset`=0 asserted during ACK -> on that edge `datack`=1, strobes and chip selects inactive, state IDLE; the next `ce` cycle completes normally.
